cla_seq_adder_ctrl: RTL

- Sequencer that reuses one 4-bit carry-lookahead slice to add WIDTH-bit operands over WIDTH/4 cycles, least significant nibble first.
- Carry passes between nibbles through a registered carry bit.
- Sits between an upstream valid/ready producer and a downstream valid/ready consumer, so wide additions share one small CLA datapath.

---
 rtl/cla_seq_pkg.sv | 25 ++
 rtl/cla4_slice.sv | 40 ++++
 rtl/cla_seq_adder_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// ============================================================================
// Module      : cla_seq_pkg
// Description : Shared slice width, sequencer states and nibble-count helper
//               for the sequential CLA adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice_f(input int width);
        return width / SLICE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla4_slice.sv
// ============================================================================
// Module      : cla4_slice
// Description : Combinational 4-bit carry-lookahead adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4_slice
    import cla_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened from g/p so none waits on a lower carry.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : cla_seq_adder_ctrl
// Description : Adds WIDTH-bit operands one nibble per cycle through a single
//               CLA slice. Define CLA_SEQ_SUB_EN to add the 'sub' port (a-b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSLICE = nslice_f(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               carry_q,     carry_d;
    logic               cout_q,      cout_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               sub_sel;

`ifdef CLA_SEQ_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign slice_a = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
    assign slice_b = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

    cla4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    // Subtraction is a + ~b + 1; the +1 rides in on the carry.
                    b_d        = sub_sel ? ~b : b;
                    carry_d    = sub_sel | cin;
                    idx_d      = '0;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[SLICE_W*int'(idx_q) +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d      = slice_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

`default_nettype wire
